uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
- Shares one uart_tx instance between NUM_REQ independent byte producers, e.g. the Forth console and debug/trace ports.
- Arbitrates by round-robin and handles uart_tx's ready/next handshake.
- Presents exactly one byte per uart_tx packet cycle.
- Sits between the producers and uart_tx in the same divided-clock domain.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DATA, 8, byte width; matches uart_tx DATA.
- IDX_BITS, $clog2(NUM_REQ), width of the grant index (localparam).

Ports:
- i_divided_clk  in  1  divided (oversample) clock, same clock as uart_tx.
- i_rst_n  in  1  asynchronous active-low reset.
- i_en  in  1  clock enable; when 0, all state and outputs hold.
- i_req_valid  in  NUM_REQ  per-requester byte available.
- i_req_data  in  NUM_REQ*DATA  packed bytes; requester k at bits [k*DATA +: DATA].
- o_req_ack  out  NUM_REQ  one-cycle pulse: requester's byte consumed.
- o_tx_data  out  DATA  byte to uart_tx i_data.
- o_tx_ready  out  1  to uart_tx i_ready.
- i_tx_next  in  1  from uart_tx o_next (1 = uart_tx idle and accepting).
- o_busy  out  1  1 whenever state is not IDLE.
- d_grant  out  IDX_BITS  index of last granted requester (debug).
- d_state  out  2  current state (debug).

Behaviour:
- Reset (async, i_rst_n=0):
  - state=IDLE; o_req_ack=0, o_tx_data=0, o_tx_ready=0, o_busy=0.
  - d_grant=NUM_REQ-1, so requester 0 wins the first arbitration.
- All transitions happen on posedge i_divided_clk with i_en=1.
- States:
  - IDLE(0): if i_tx_next=1 and |i_req_valid:
    - g = first valid index searching d_grant+1, d_grant+2, ... modulo NUM_REQ.
    - Register o_tx_data=i_req_data[g], o_tx_ready=1, o_req_ack[g]=1, d_grant=g.
    - Go to OFFER.
    - Otherwise stay in IDLE with all outputs 0.
  - OFFER(1): o_req_ack=0 unconditionally. If i_tx_next=0 (uart_tx latched the byte), o_tx_ready=0 and go to SEND. Otherwise hold o_tx_ready=1 and o_tx_data.
  - SEND(2): wait for i_tx_next=1, which marks the end of stop and cooldown, then go to IDLE. Do not arbitrate in the same cycle.
  - State 3 is illegal: return to IDLE and clear o_tx_ready and o_req_ack.
- Latency:
  - Valid with uart_tx idle -> o_tx_ready and ack on the next edge: 1 cycle.
  - Minimum gap between grants is 3 cycles plus the uart_tx packet time.
- o_req_ack pulses exactly once per byte. A requester must hold data stable while valid until its ack. The requester may drop valid or change data the cycle after ack.
- Requesters that drop valid before being granted are simply skipped; no byte is sent for them.
- Simultaneous requests: exactly one grant. Round-robin guarantees each continuously-valid requester is served within NUM_REQ grants.
- i_tx_next=0 in IDLE: no grant, no ack. This covers the post-reset state, where uart_tx o_next starts at 0.
- i_en=0 mid-operation: freeze. o_req_ack keeps its value; benches must not rely on ack while i_en=0.
- Reset mid-OFFER or mid-SEND: immediate return to reset values. The in-flight byte counts as consumed if its ack has already pulsed.

Optional Feature:
- Macro UART_TX_ARB_FIXED_PRI_EN.
- Defined: fixed priority, lowest valid index always wins. d_grant still records the winner, but the search ignores it.
- Undefined (default): round-robin as specified above.

Test Plan:
- Reset, then i_tx_next=1, i_req_valid=4'b0001, data0=8'hA5 -> next edge: o_tx_ready=1, o_tx_data=8'hA5, o_req_ack=4'b0001 for 1 cycle, d_grant=0.
- All four valid with uart_tx model (next drops 1 cycle after ready, rises 20 cycles later) -> grant order 0,1,2,3,0, one ack per byte. With UART_TX_ARB_FIXED_PRI_EN: order 0,0,0.
- d_grant=1, i_req_valid=4'b1001 -> grant 3, then 0.
- i_tx_next held 0 with valid=4'b1111 for 50 cycles -> no o_tx_ready, no ack, o_busy=0.
- i_rst_n asserted in SEND -> o_busy, o_tx_ready and o_req_ack go 0 asynchronously; d_grant=NUM_REQ-1; first grant after release goes to requester 0.
- i_en=0 for 10 cycles while in OFFER -> o_tx_ready and o_tx_data unchanged, no state change; resumes to SEND when i_en=1 and i_tx_next=0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx between NUM_REQ byte producers, round-robin by default.
// Define UART_TX_ARB_FIXED_PRI_EN to make the lowest valid index always win instead.
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA    = 8,
  localparam int IDX_BITS = $clog2(NUM_REQ)
) (
  input  logic                    i_divided_clk,
  input  logic                    i_rst_n,
  input  logic                    i_en,
  input  logic [NUM_REQ-1:0]      i_req_valid,
  input  logic [NUM_REQ*DATA-1:0] i_req_data,
  output logic [NUM_REQ-1:0]      o_req_ack,
  output logic [DATA-1:0]         o_tx_data,
  output logic                    o_tx_ready,
  input  logic                    i_tx_next,
  output logic                    o_busy,
  output logic [IDX_BITS-1:0]     d_grant,
  output logic [1:0]              d_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    SEND  = 2'd2,
    BAD   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [NUM_REQ-1:0]  req_ack_q, req_ack_d;
  logic [DATA-1:0]     tx_data_q, tx_data_d;
  logic                tx_ready_q, tx_ready_d;
  logic [IDX_BITS-1:0] grant_q, grant_d;
  logic [IDX_BITS-1:0] sel;
  logic [DATA-1:0]     req_bytes [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign req_bytes[gi] = i_req_data[gi*DATA +: DATA];
    end
  endgenerate

`ifdef UART_TX_ARB_FIXED_PRI_EN
  always_comb begin
    sel = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (i_req_valid[IDX_BITS'(k)]) sel = IDX_BITS'(k);
    end
  end
`else
  int cand;

  // Scan from the farthest candidate back to grant_q+1 so the nearest valid one wins.
  always_comb begin
    sel  = '0;
    cand = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = int'(grant_q) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (i_req_valid[IDX_BITS'(cand)]) sel = IDX_BITS'(cand);
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    req_ack_d  = req_ack_q;
    tx_data_d  = tx_data_q;
    tx_ready_d = tx_ready_q;
    grant_d    = grant_q;
    case (state_q)
      IDLE: begin
        req_ack_d  = '0;
        tx_ready_d = 1'b0;
        tx_data_d  = '0;
        if (i_tx_next && (|i_req_valid)) begin
          state_d        = OFFER;
          tx_data_d      = req_bytes[sel];
          tx_ready_d     = 1'b1;
          req_ack_d[sel] = 1'b1;
          grant_d        = sel;
        end
      end
      OFFER: begin
        req_ack_d = '0;
        // uart_tx drops o_next once it has latched the byte
        if (!i_tx_next) begin
          tx_ready_d = 1'b0;
          state_d    = SEND;
        end
      end
      SEND: begin
        req_ack_d  = '0;
        tx_ready_d = 1'b0;
        if (i_tx_next) state_d = IDLE;
      end
      default: begin
        state_d    = IDLE;
        tx_ready_d = 1'b0;
        req_ack_d  = '0;
      end
    endcase
  end

  always_ff @(posedge i_divided_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      req_ack_q  <= '0;
      tx_data_q  <= '0;
      tx_ready_q <= 1'b0;
      grant_q    <= IDX_BITS'(NUM_REQ - 1);
    end else if (i_en) begin
      state_q    <= state_d;
      req_ack_q  <= req_ack_d;
      tx_data_q  <= tx_data_d;
      tx_ready_q <= tx_ready_d;
      grant_q    <= grant_d;
    end
  end

  assign o_req_ack  = req_ack_q;
  assign o_tx_data  = tx_data_q;
  assign o_tx_ready = tx_ready_q;
  assign o_busy     = (state_q != IDLE);
  assign d_grant    = grant_q;
  assign d_state    = state_q;

endmodule
